tx_handshake_4phase: RTL and testbench

- Transmit end of the two-flop-synchronised four-phase req/ack link between the clk_tx and clk_rx domains.
- Accepts words from a local producer and holds each one stable on the data bus.
- Drives req and synchronises the receiver's ack back into clk_tx with a SYNC_STAGES flop chain.
- Sequences the return-to-zero handshake, one word per complete four-phase cycle.

---
 rtl/tx_handshake_4phase.sv | 123 ++++++++++++
 tb/tb_tx_handshake_4phase.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_handshake_4phase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tx_handshake_4phase                                           |
// | Purpose  : Transmit side of a four-phase req/ack link; ack synchronised  |
// |            into clk_tx. Define TX_SKID_EN for a one-word skid register.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tx_handshake_4phase #(
    parameter int DATA_MSB    = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_tx,
    input  logic              reset,
    input  logic              vi,
    input  logic [DATA_MSB:0] tdata,
    input  logic              ack,
    output logic              req,
    output logic [DATA_MSB:0] data,
    output logic              stall,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_req;
    logic                   r_done;
    logic [DATA_MSB:0]      r_data;

    logic                   w_ack_s;
    logic                   w_idle_ready;
    logic                   w_launch;
    logic [DATA_MSB:0]      w_launch_data;

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
        end
    end

    assign w_ack_s      = r_ack_sync[SYNC_STAGES-1];
    assign w_idle_ready = (r_state == ST_IDLE) && !w_ack_s;

`ifdef TX_SKID_EN
    logic              r_skid_full;
    logic [DATA_MSB:0] r_skid_data;
    logic              w_accept;
    logic              w_skid_launch;
    logic              w_skid_load;

    // Stall drops on the skid-launch cycle so a held word refills the skid
    // exactly once instead of being taken without the producer noticing.
    assign stall         = ~reset | (r_skid_full & ~w_idle_ready);
    assign w_accept      = vi & ~stall;
    assign w_skid_launch = w_idle_ready & r_skid_full;
    assign w_launch      = w_idle_ready & (r_skid_full | vi);
    assign w_launch_data = r_skid_full ? r_skid_data : tdata;
    assign w_skid_load   = w_accept & ~(w_idle_ready & ~r_skid_full);
`else
    assign stall         = ~reset | ~w_idle_ready;
    assign w_launch      = w_idle_ready & vi;
    assign w_launch_data = tdata;
`endif

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
`ifdef TX_SKID_EN
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_data  <= w_launch_data;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!w_ack_s) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef TX_SKID_EN
            if (w_skid_load) begin
                r_skid_data <= tdata;
            end
            r_skid_full <= w_skid_load | (r_skid_full & ~w_skid_launch);
`endif
        end
    end

    assign req  = r_req;
    assign data = r_data;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_handshake_4phase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tx_handshake_4phase                                        |
// | Purpose  : Directed and randomised handshakes for tx_handshake_4phase.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tx_handshake_4phase;

    localparam int DATA_MSB = 7;
    localparam int S        = 2;

    logic              clk_tx = 1'b0;
    logic              reset;
    logic              vi;
    logic [DATA_MSB:0] tdata;
    logic              ack;
    logic              req;
    logic [DATA_MSB:0] data;
    logic              stall;
    logic              done;

    int n_checks    = 0;
    int n_fail      = 0;
    int n_done_seen = 0;
    int n_done_exp  = 0;
    logic [7:0] sent_q[$];
    logic [7:0] last_word = 8'h00;

    tx_handshake_4phase #(
        .DATA_MSB   (DATA_MSB),
        .SYNC_STAGES(S)
    ) dut (
        .clk_tx(clk_tx),
        .reset (reset),
        .vi    (vi),
        .tdata (tdata),
        .ack   (ack),
        .req   (req),
        .data  (data),
        .stall (stall),
        .done  (done)
    );

    always #5 clk_tx = ~clk_tx;

    always @(negedge clk_tx) if (done === 1'b1) n_done_seen++;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    // Present a word while the transmitter is ready; it must launch next edge.
    task automatic accept(input logic [7:0] w);
        chk_b("pre_stall", stall, 1'b0);
        vi    = 1'b1;
        tdata = w;
        tick();
        sent_q.push_back(w);
        last_word = w;
        chk_b("req_rise", req, 1'b1);
        chk_d("data_load", data, w);
        chk_b("stall_busy", stall, 1'b1);
        chk_b("done_single", done, 1'b0);
    endtask

    task automatic noise_or(input bit noise, input logic nv, input logic [7:0] nw);
        if (noise) begin
            vi    = 1'($urandom_range(0, 1));
            tdata = 8'($urandom);
        end else begin
            vi    = nv;
            tdata = nw;
        end
    endtask

    // Bench receiver: ack d1 cycles after req, drop d2 cycles after req falls.
    task automatic handshake(input logic [7:0] w, input int d1, input int d2,
                             input bit noise, input logic nxt_vi, input logic [7:0] nxt_word);
        logic [7:0] exp_w;
        noise_or(noise, nxt_vi, nxt_word);
        for (int i = 0; i < d1; i++) begin
            tick();
            noise_or(noise, nxt_vi, nxt_word);
            chk_b("req_hold", req, 1'b1);
            chk_d("data_hold_req", data, w);
            chk_b("stall_req", stall, 1'b1);
        end
        exp_w = sent_q.pop_front();
        chk_d("rx_order", data, exp_w);
        ack = 1'b1;
        for (int i = 1; i <= S + 1; i++) begin
            tick();
            noise_or(noise, nxt_vi, nxt_word);
            chk_b("req_fall_latency", req, (i == S + 1) ? 1'b0 : 1'b1);
            chk_d("data_hold_ack", data, w);
            chk_b("stall_ack", stall, 1'b1);
        end
        for (int i = 0; i < d2; i++) begin
            tick();
            noise_or(noise, nxt_vi, nxt_word);
            chk_b("req_low_rel", req, 1'b0);
            chk_d("data_hold_rel", data, w);
            chk_b("done_early", done, 1'b0);
            chk_b("stall_rel", stall, 1'b1);
        end
        vi    = nxt_vi;
        tdata = nxt_word;
        ack   = 1'b0;
        for (int i = 1; i <= S + 1; i++) begin
            tick();
            chk_b("done_latency", done, (i == S + 1) ? 1'b1 : 1'b0);
            chk_d("data_hold_done", data, w);
            chk_b("req_low_done", req, 1'b0);
            chk_b("stall_until_done", stall, (i == S + 1) ? 1'b0 : 1'b1);
        end
        n_done_exp++;
    endtask

    task automatic idle_gap(input int n);
        vi = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_b("idle_req", req, 1'b0);
            chk_b("idle_stall", stall, 1'b0);
            chk_b("idle_done", done, 1'b0);
            chk_d("idle_data", data, last_word);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] nxt;
        logic       nb;

        reset = 1'b0;
        vi    = 1'b0;
        tdata = 8'h00;
        ack   = 1'b0;
        tick();
        tick();
        chk_b("rst_req", req, 1'b0);
        chk_d("rst_data", data, 8'h00);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_stall", stall, 1'b1);
        reset = 1'b1;
        idle_gap(2);

        // Single word
        accept(8'hA5);
        handshake(8'hA5, 3, 3, 1'b0, 1'b0, 8'h00);
        idle_gap(1);

        // Back-to-back: second word held during the first handshake
        accept(8'h01);
        handshake(8'h01, 2, 1, 1'b0, 1'b1, 8'h02);
        accept(8'h02);
        handshake(8'h02, 1, 2, 1'b0, 1'b0, 8'h00);
        idle_gap(1);

        // Producer inputs toggle throughout the handshake
        accept(8'h5A);
        handshake(8'h5A, 4, 4, 1'b1, 1'b0, 8'h00);
        idle_gap(1);

        // Stale ack across reset release
        reset = 1'b0;
        ack   = 1'b1;
        tick();
        chk_b("rst_stall_ack", stall, 1'b1);
        chk_d("rst_data2", data, 8'h00);
        last_word = 8'h00;
        reset = 1'b1;
        for (int i = 0; i < S; i++) tick();
        chk_b("stale_stall", stall, 1'b1);
        vi    = 1'b1;
        tdata = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_b("stale_req", req, 1'b0);
            chk_b("stale_stall_hold", stall, 1'b1);
            chk_d("stale_data", data, 8'h00);
        end
        ack = 1'b0;
        for (int i = 1; i <= S; i++) begin
            tick();
            chk_b("stale_req_wait", req, 1'b0);
            chk_b("stale_release", stall, (i == S) ? 1'b0 : 1'b1);
        end
        tick();
        sent_q.push_back(8'h3C);
        last_word = 8'h3C;
        chk_b("stale_launch_req", req, 1'b1);
        chk_d("stale_launch_data", data, 8'h3C);
        handshake(8'h3C, 2, 2, 1'b0, 1'b0, 8'h00);
        idle_gap(1);

        // Asynchronous reset in the middle of a handshake
        accept(8'hFF);
        vi = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        #3 reset = 1'b0;
        #1;
        chk_b("midrst_req", req, 1'b0);
        chk_d("midrst_data", data, 8'h00);
        chk_b("midrst_done", done, 1'b0);
        chk_b("midrst_stall", stall, 1'b1);
        sent_q.delete();
        last_word = 8'h00;
        ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        idle_gap(3);

        // Randomised traffic against the sequence model
        w = 8'($urandom);
        for (int k = 0; k < 24; k++) begin
            accept(w);
            nb  = (k == 23) ? 1'b0 : 1'($urandom_range(0, 1));
            nxt = 8'($urandom);
            handshake(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), nb, nxt);
            w = nxt;
            if (!nb) idle_gap(int'($urandom_range(1, 3)));
        end

        tick();
        n_checks++;
        assert (n_done_seen == n_done_exp) else begin
            n_fail++;
            $error("FAIL done_count: observed %0d expected %0d", n_done_seen, n_done_exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
